// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
package dmem_arbiter_pkg;
   localparam int unsigned WORD       = 64;
   localparam int unsigned DMEM_DEPTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_C = 1'b0,
      OWN_D = 1'b1
   } owner_t;
endpackage

// File: rtl/dmem_arbiter_pick.sv
// Grant selector for the data-memory arbiter.
// DMEM_RR_ARB_EN selects round-robin; otherwise C has fixed priority over D.
module dmem_arb_pick
   import dmem_arbiter_pkg::*;
(
   input  logic   i_c_req,
   input  logic   i_d_req,
   input  owner_t i_last_grant,
   output owner_t o_owner
);

   always_comb begin
      // With no request the result is never latched; returning last_grant keeps it harmless.
      o_owner = i_last_grant;
`ifdef DMEM_RR_ARB_EN
      if (i_c_req && i_d_req)
         o_owner = (i_last_grant == OWN_C) ? OWN_D : OWN_C;
      else if (i_c_req)
         o_owner = OWN_C;
      else if (i_d_req)
         o_owner = OWN_D;
`else
      if (i_c_req)
         o_owner = OWN_C;
      else if (i_d_req)
         o_owner = OWN_D;
`endif
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (C) and debug/DMA (D) ports.
// Arbitration mode is chosen by DMEM_RR_ARB_EN inside dmem_arb_pick.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned WORD_W = WORD,
   parameter int unsigned DEPTH  = DMEM_DEPTH
) (
   input  logic              im_clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [WORD_W-1:0] c_addr,
   input  logic [WORD_W-1:0] c_wdata,
   output logic [WORD_W-1:0] c_rdata,
   output logic              c_done,
   output logic              c_err,
   output logic              c_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [WORD_W-1:0] d_addr,
   input  logic [WORD_W-1:0] d_wdata,
   output logic [WORD_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata
);

   localparam logic [WORD_W-1:0] LIMIT = WORD_W'(DEPTH);

   state_t            r_state, w_next;
   owner_t            r_owner, r_last_grant, w_pick;
   logic              r_we, r_err, w_bad;
   logic [WORD_W-1:0] r_addr, r_wdata;
   logic              r_c_done, r_c_err, r_d_done, r_d_err;
   logic [WORD_W-1:0] r_c_rdata, r_d_rdata;

   dmem_arb_pick u_pick (
      .i_c_req      (c_req),
      .i_d_req      (d_req),
      .i_last_grant (r_last_grant),
      .o_owner      (w_pick)
   );

   assign w_bad = (r_addr[2:0] != 3'b000) || ((r_addr >> 3) >= LIMIT);

   always_ff @(posedge im_clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (r_state)
         ST_IDLE:  if (c_req || d_req) w_next = ST_ISSUE;
         ST_ISSUE: begin
            w_next = ST_RESP;
            if (!w_bad) begin
               mem_read  = !r_we;
               mem_write = r_we;
               mem_addr  = r_addr;
               mem_wdata = r_wdata;
            end
         end
         ST_RESP:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge im_clk) begin
      if (reset) begin
         r_owner      <= OWN_C;
         r_last_grant <= OWN_D;
         r_we         <= 1'b0;
         r_err        <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_c_done     <= 1'b0;
         r_c_err      <= 1'b0;
         r_c_rdata    <= '0;
         r_d_done     <= 1'b0;
         r_d_err      <= 1'b0;
         r_d_rdata    <= '0;
      end else begin
         r_c_done <= 1'b0;
         r_c_err  <= 1'b0;
         r_d_done <= 1'b0;
         r_d_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (c_req || d_req) begin
                  r_owner <= w_pick;
                  if (w_pick == OWN_D) begin
                     r_we    <= d_we;
                     r_addr  <= d_addr;
                     r_wdata <= d_wdata;
                  end else begin
                     r_we    <= c_we;
                     r_addr  <= c_addr;
                     r_wdata <= c_wdata;
                  end
               end
            end
            ST_ISSUE: r_err <= w_bad;
            ST_RESP: begin
               r_last_grant <= r_owner;
               if (r_owner == OWN_C) begin
                  r_c_done  <= 1'b1;
                  r_c_err   <= r_err;
                  r_c_rdata <= (!r_we && !r_err) ? mem_rdata : '0;
               end else begin
                  r_d_done  <= 1'b1;
                  r_d_err   <= r_err;
                  r_d_rdata <= (!r_we && !r_err) ? mem_rdata : '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign c_done  = r_c_done;
   assign c_err   = r_c_err;
   assign c_rdata = r_c_rdata;
   assign d_done  = r_d_done;
   assign d_err   = r_d_err;
   assign d_rdata = r_d_rdata;
   assign c_stall = c_req && !r_c_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

   logic        im_clk = 1'b0;
   logic        reset;
   logic        c_req, c_we, d_req, d_we;
   logic [63:0] c_addr, c_wdata, d_addr, d_wdata;
   logic [63:0] c_rdata, d_rdata;
   logic        c_done, c_err, c_stall, d_done, d_err;
   logic        mem_read, mem_write;
   logic [63:0] mem_addr, mem_wdata;
   logic [63:0] mem_rdata = '0;
   logic [63:0] mem [0:31];

   int n_checks = 0;
   int n_errors = 0;

   always #5 im_clk = ~im_clk;

   dmem_arbiter #(.WORD_W(64), .DEPTH(32)) dut (
      .im_clk    (im_clk),
      .reset     (reset),
      .c_req     (c_req),
      .c_we      (c_we),
      .c_addr    (c_addr),
      .c_wdata   (c_wdata),
      .c_rdata   (c_rdata),
      .c_done    (c_done),
      .c_err     (c_err),
      .c_stall   (c_stall),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_done    (d_done),
      .d_err     (d_err),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Data memory: synchronous write, registered read.
   always @(posedge im_clk) begin
      if (mem_write) mem[mem_addr[7:3]] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr[7:3]];
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge im_clk) check_eq("rw_excl", {63'd0, mem_read & mem_write}, 64'd0);

   // Drives one access on port (0=C, 1=D) from a negedge and waits for its done.
   task automatic access(input bit port, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rdata, output logic err, output int lat,
                         output int n_mr, output int n_mw, output int n_st);
      bit got = 0;
      lat = 0; n_mr = 0; n_mw = 0; n_st = 0; rdata = '0; err = 1'b0;
      if (port == 1'b0) begin
         c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
      end else begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge im_clk);
         lat++;
         if (mem_read)  n_mr++;
         if (mem_write) n_mw++;
         if (mem_read || mem_write) check_eq("mem_addr", mem_addr, addr);
         if (mem_write) check_eq("mem_wdata", mem_wdata, wdata);
         if (port == 1'b0 && c_stall) n_st++;
         check_eq("other_done", {63'd0, (port == 1'b0) ? d_done : c_done}, 64'd0);
         if (port == 1'b0 && c_done) begin
            got = 1; rdata = c_rdata; err = c_err; c_req = 1'b0;
         end else if (port == 1'b1 && d_done) begin
            got = 1; rdata = d_rdata; err = d_err; d_req = 1'b0;
         end
      end
      check_eq("done_seen", {63'd0, got}, 64'd1);
   endtask

   // Both ports read together; reports the negedge index at which each done appears.
   task automatic pair(input int exp_c, input int exp_d);
      int tc = 0, td = 0;
      c_req = 1'b1; c_we = 1'b0; c_addr = 64'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 64'hF8;
      for (int i = 1; i <= 12 && (tc == 0 || td == 0); i++) begin
         @(negedge im_clk);
         if (c_done) begin
            tc = i; c_req = 1'b0;
            check_eq("pair_c_rdata", c_rdata, 64'hDEADBEEF);
         end
         if (d_done) begin
            td = i; d_req = 1'b0;
            check_eq("pair_d_rdata", d_rdata, 64'h1);
         end
      end
      check_eq("pair_c_time", tc, exp_c);
      check_eq("pair_d_time", td, exp_d);
   endtask

   logic [63:0] rd;
   logic        er;
   int          lat, nmr, nmw, nst, ndone, t;

   initial begin
      reset = 1'b1;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (2) @(negedge im_clk);
      check_eq("rst_c_done", {63'd0, c_done}, 64'd0);
      check_eq("rst_d_done", {63'd0, d_done}, 64'd0);
      check_eq("rst_c_rdata", c_rdata, 64'd0);
      check_eq("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
      check_eq("rst_mem_addr", mem_addr, 64'd0);
      check_eq("rst_c_stall", {63'd0, c_stall}, 64'd0);
      reset = 1'b0;
      @(negedge im_clk);

      // C write then read back
      access(1'b0, 1'b1, 64'h10, 64'hDEADBEEF, rd, er, lat, nmr, nmw, nst);
      check_eq("wr_lat", lat, 3);
      check_eq("wr_nmw", nmw, 1);
      check_eq("wr_nmr", nmr, 0);
      check_eq("wr_err", {63'd0, er}, 64'd0);
      check_eq("wr_stall", nst, 2);
      @(negedge im_clk);
      access(1'b0, 1'b0, 64'h10, 64'd0, rd, er, lat, nmr, nmw, nst);
      check_eq("rd_data", rd, 64'hDEADBEEF);
      check_eq("rd_err", {63'd0, er}, 64'd0);
      check_eq("rd_nmr", nmr, 1);
      check_eq("rd_lat", lat, 3);

      // Rejected addresses: misaligned, then one past the last word
      access(1'b0, 1'b0, 64'h0C, 64'd0, rd, er, lat, nmr, nmw, nst);
      check_eq("mis_err", {63'd0, er}, 64'd1);
      check_eq("mis_rdata", rd, 64'd0);
      check_eq("mis_mem", nmr + nmw, 0);
      @(negedge im_clk);
      access(1'b0, 1'b0, 64'h100, 64'd0, rd, er, lat, nmr, nmw, nst);
      check_eq("oor_err", {63'd0, er}, 64'd1);
      check_eq("oor_rdata", rd, 64'd0);
      check_eq("oor_mem", nmr + nmw, 0);

      // D write to last word, C reads it
      @(negedge im_clk);
      access(1'b1, 1'b1, 64'hF8, 64'h1, rd, er, lat, nmr, nmw, nst);
      check_eq("dwr_err", {63'd0, er}, 64'd0);
      check_eq("dwr_nmw", nmw, 1);
      @(negedge im_clk);
      access(1'b0, 1'b0, 64'hF8, 64'd0, rd, er, lat, nmr, nmw, nst);
      check_eq("last_rdata", rd, 64'h1);

      // Simultaneous requests; last grant before the first pair is C
      @(negedge im_clk);
`ifdef DMEM_RR_ARB_EN
      pair(6, 3);
      @(negedge im_clk);
      pair(6, 3);
`else
      pair(3, 6);
      @(negedge im_clk);
      pair(3, 6);
`endif

      // Reset during RESP aborts the access; held request restarts it
      @(negedge im_clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 64'h10;
      repeat (2) @(negedge im_clk);
      reset = 1'b1;
      @(negedge im_clk);
      check_eq("rip_c_done", {63'd0, c_done}, 64'd0);
      check_eq("rip_c_rdata", c_rdata, 64'd0);
      check_eq("rip_d_rdata", d_rdata, 64'd0);
      check_eq("rip_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
      reset = 1'b0;
      t = 0;
      for (int i = 1; i <= 8 && t == 0; i++) begin
         @(negedge im_clk);
         if (c_done) begin
            t = i; c_req = 1'b0;
            check_eq("rip_rdata", c_rdata, 64'hDEADBEEF);
         end
      end
      check_eq("rip_restart", t, 3);

      // Continuous request: four reads, one every three cycles
      @(negedge im_clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 64'hF8;
      ndone = 0;
      for (int i = 1; i <= 20 && ndone < 4; i++) begin
         @(negedge im_clk);
         if (c_done) begin
            ndone++;
            check_eq("cont_pos", i, 3 * ndone);
            check_eq("cont_rdata", c_rdata, 64'h1);
            if (ndone == 4) c_req = 1'b0;
         end
      end
      check_eq("cont_count", ndone, 4);
      repeat (4) begin
         @(negedge im_clk);
         check_eq("cont_quiet", {63'd0, c_done}, 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Sequences and shares the 64-bit single-port data memory between two requesters: the CPU MEM stage (port C) and the debug/DMA loader (port D). Drives the memory's mem_read, mem_write, alu_result (byte address) and read_data2 (write data) inputs, and captures its registered read_data. Returns a one-cycle done pulse and stalls the CPU while its access is pending. Rejects misaligned or out-of-range addresses without touching memory.

Parameters:
WORD_W, 64 (`WORD), data and address width
DEPTH, 32, memory words; the valid byte range is 0 .. DEPTH*8-1

Ports:
im_clk  in  1  clock shared with data memory; all logic on posedge
reset  in  1  synchronous, active-high
c_req  in  1  CPU access request; held until c_done
c_we  in  1  1 = write, 0 = read
c_addr  in  WORD_W  byte address
c_wdata  in  WORD_W  write data
c_rdata  out  WORD_W  read data, valid while c_done
c_done  out  1  one-cycle completion pulse
c_err  out  1  qualifies c_done: access rejected
c_stall  out  1  c_req && !c_done (combinational)
d_req, d_we, d_addr, d_wdata, d_rdata, d_done, d_err  same as the c_ ports, for the debug/DMA port
mem_read  out  1  to data memory
mem_write  out  1  to data memory
mem_addr  out  WORD_W  drives memory alu_result; byte address
mem_wdata  out  WORD_W  drives memory read_data2
mem_rdata  in  WORD_W  from memory read_data; valid the cycle after mem_read

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- Reset values: state=IDLE; all done and err outputs 0; rdata outputs 0; mem_read=mem_write=0; mem_addr=mem_wdata=0; owner=C; last_grant=D.
- IDLE: if any req is active, select the owner by the arbitration rule, latch the owner's we/addr/wdata, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - Check the latched address: misaligned (addr[2:0]!=0) or out of range (addr>>3 >= DEPTH) sets the error flag. No mem_read/mem_write is issued.
  - Otherwise assert mem_read (read) or mem_write (write) for exactly this cycle, with mem_addr and mem_wdata driven from the latches.
  - Next state: RESP.
- RESP (1 cycle):
  - Pulse owner_done. owner_err is set to the error flag.
  - For a read with no error, owner_rdata = mem_rdata. Otherwise owner_rdata = 0.
  - Update last_grant to the owner, then go to IDLE.
- Latency: request seen in IDLE, done 3 edges later. Back-to-back throughput is one access per 3 cycles.
- The requester must deassert req, or present a new access, in the cycle after done. A req still high in IDLE starts a new access.
- The non-owner's done/err are never asserted. Its rdata holds its last value.
- mem_read and mem_write are never asserted together. Both are 0 outside ISSUE.
- Request inputs that change after latching are ignored until the next IDLE.
- Reset asserted in any state forces the reset values on the next edge. An access in flight is aborted and no done is issued. A write asserted in the same ISSUE cycle as reset still reaches memory.
- Fixed priority (default): C wins whenever both requesters are active.

Optional Feature:
DMEM_RR_ARB_EN
- Defined: round-robin arbitration. On simultaneous requests, the requester that is not last_grant wins. A single requester always wins.
- Undefined: fixed priority, C over D. last_grant is still maintained but unused.

Decomposition:
- Shared package/header (definitions.vh):
  - `WORD.
  - FSM state encodings ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2.
  - Owner encodings OWN_C=1'b0, OWN_D=1'b1.
  - DMEM_DEPTH.
- One sub-module, dmem_arb_pick: a combinational grant selector taking c_req, d_req and last_grant, producing the owner. It isolates the DMEM_RR_ARB_EN choice.

Test Plan:
- Reset, then C write addr=0x10 data=0xDEADBEEF, then C read addr=0x10: mem_write is high only in the ISSUE cycle with mem_addr=0x10; the read gives c_done with c_rdata=0xDEADBEEF and c_err=0; c_stall is high for 2 cycles and drops when c_done pulses.
- c_req and d_req rise together, both reads, under fixed priority: C is done first, and D is done 3 cycles later. With DMEM_RR_ARB_EN, a second simultaneous pair is served D first.
- C read at addr=0x0C (misaligned), then addr=0x100 (DEPTH*8): each returns c_done with c_err=1 and c_rdata=0; mem_read and mem_write stay 0 throughout.
- D write addr=0xF8 (last word) of 0x1: the access succeeds, and a C read of 0xF8 returns 0x1.
- Reset asserted during RESP of a C read: no c_done, state is IDLE, and all outputs are 0 the next cycle; with c_req still high, the access restarts and completes 3 cycles after reset drops.
- Continuous c_req for 4 reads: exactly 4 c_done pulses spaced 3 cycles apart; a scoreboard checks mem_read and mem_write are never high together.
